id_inst_buffer: RTL and testbench

Parametrised instruction buffer between IF and ID, replacing the single-entry stall buffer inside the decode stage. Each fetch request is allocated an entry with its PC at request time. The synchronous instruction SRAM's read data is captured into that entry one cycle later. ID drains the buffer in order, and a branch redirect flushes it, so a fetch stall never loses an instruction.

---
 rtl/id_inst_buffer_pkg.sv | 15 +
 rtl/id_inst_buffer.sv | 101 ++++++++++
 tb/tb_id_inst_buffer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/id_inst_buffer_pkg.sv
// Shared widths and bundle types for the IF -> ID instruction buffer.
// Default sizing plus the {valid, pc} request bus.
package id_inst_buffer_pkg;

  localparam int IBUF_DEPTH    = 4;
  localparam int IBUF_PTR_W    = $clog2(IBUF_DEPTH);
  localparam int IF_PC_W       = 32;
  localparam int IF_TO_IBUF_WD = 1 + IF_PC_W;

  typedef struct packed {
    logic               valid;
    logic [IF_PC_W-1:0] pc;
  } if_to_ibuf_t;

endpackage

// File: rtl/id_inst_buffer.sv
// In-order instruction buffer between IF and ID with deferred SRAM fill.
// The head may bypass the SRAM data in the cycle its fill arrives.
module id_inst_buffer
  import id_inst_buffer_pkg::*;
#(
  parameter int DEPTH  = IBUF_DEPTH,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req_valid,
  input  logic [PC_W-1:0]          if_req_pc,
  output logic                     if_req_ready,
  input  logic [INST_W-1:0]        inst_sram_rdata,
  input  logic                     flush,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [PC_W-1:0]          id_pc,
  output logic [INST_W-1:0]        id_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [DEPTH-1:0]  filled_q;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [PTR_W-1:0]  pend_idx_q;
  logic              pend_v_q;
  logic [CNT_W-1:0]  count_q;

  logic push;
  logic pop;
  logic head_pend;

  assign if_req_ready = ~flush & (count_q != FULL);
  assign push         = if_req_valid & if_req_ready;
  assign pop          = id_valid & id_ready;
  assign count        = count_q;
  assign head_pend    = pend_v_q & (pend_idx_q == head_q);

  always_comb begin
    id_valid = 1'b0;
    id_pc    = '0;
    id_inst  = '0;
    if (count_q != '0 && (filled_q[head_q] || head_pend)) begin
      id_valid = 1'b1;
      id_pc    = pc_q[head_q];
      id_inst  = head_pend ? inst_sram_rdata : inst_q[head_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      pend_idx_q <= '0;
      pend_v_q   <= 1'b0;
      count_q    <= '0;
      filled_q   <= '0;
    end else if (flush) begin
      head_q     <= '0;
      tail_q     <= '0;
      pend_v_q   <= 1'b0;
      count_q    <= '0;
      filled_q   <= '0;
    end else begin
      if (pend_v_q)
        filled_q[pend_idx_q] <= 1'b1;
      // tail never aliases the pending slot while a push is allowed
      if (push) begin
        filled_q[tail_q] <= 1'b0;
        tail_q           <= tail_q + 1'b1;
        pend_idx_q       <= tail_q;
      end
      pend_v_q <= push;
      if (pop)
        head_q <= head_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (pend_v_q)
        inst_q[pend_idx_q] <= inst_sram_rdata;
      if (push)
        pc_q[tail_q] <= if_req_pc;
    end
  end

endmodule

// File: tb/tb_id_inst_buffer.sv
// Directed bench for id_inst_buffer: vector table plus
// hand sequences for hold, wrap and async reset.
module tb_id_inst_buffer;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_req_pc;
  logic        if_req_ready;
  logic [31:0] inst_sram_rdata;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  id_inst_buffer #(
    .DEPTH (4),
    .PC_W  (32),
    .INST_W(32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid   (if_req_valid),
    .if_req_pc      (if_req_pc),
    .if_req_ready   (if_req_ready),
    .inst_sram_rdata(inst_sram_rdata),
    .flush          (flush),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic [31:0] rd;
    logic        fl;
    logic        idr;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [2:0]  ecnt;
    logic        erdy;
  } vec_t;

  vec_t tv[16];

  function automatic vec_t mk(
    input logic req, input logic [31:0] pc, input logic [31:0] rd,
    input logic fl, input logic idr, input logic ev,
    input logic [31:0] epc, input logic [31:0] einst,
    input logic [2:0] ecnt, input logic erdy);
    vec_t v;
    v.req = req; v.pc = pc; v.rd = rd; v.fl = fl; v.idr = idr;
    v.ev = ev; v.epc = epc; v.einst = einst; v.ecnt = ecnt; v.erdy = erdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [31:0] pc,
                       input logic [31:0] rd, input logic fl,
                       input logic idr);
    if_req_valid    = req;
    if_req_pc       = pc;
    inst_sram_rdata = rd;
    flush           = fl;
    id_ready        = idr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // single fetch
    tv[0]  = mk(1, 32'hBFC00000, 32'h0,        0, 1, 0, 32'h0,        32'h0,        3'd0, 1);
    tv[1]  = mk(0, 32'h0,        32'h3C011234, 0, 1, 1, 32'hBFC00000, 32'h3C011234, 3'd1, 1);
    tv[2]  = mk(0, 32'h0,        32'hDEADBEEF, 0, 1, 0, 32'h0,        32'h0,        3'd0, 1);
    // stall fill to full, then drain
    tv[3]  = mk(1, 32'h00,       32'h0,        0, 0, 0, 32'h0,        32'h0,        3'd0, 1);
    tv[4]  = mk(1, 32'h04,       32'h11110000, 0, 0, 1, 32'h00,       32'h11110000, 3'd1, 1);
    tv[5]  = mk(1, 32'h08,       32'h11110004, 0, 0, 1, 32'h00,       32'h11110000, 3'd2, 1);
    tv[6]  = mk(1, 32'h0C,       32'h11110008, 0, 0, 1, 32'h00,       32'h11110000, 3'd3, 1);
    tv[7]  = mk(1, 32'h10,       32'h1111000C, 0, 0, 1, 32'h00,       32'h11110000, 3'd4, 0);
    tv[8]  = mk(1, 32'h10,       32'h99999999, 0, 1, 1, 32'h00,       32'h11110000, 3'd4, 0);
    tv[9]  = mk(0, 32'h0,        32'h99999999, 0, 1, 1, 32'h04,       32'h11110004, 3'd3, 1);
    tv[10] = mk(0, 32'h0,        32'h99999999, 0, 1, 1, 32'h08,       32'h11110008, 3'd2, 1);
    tv[11] = mk(0, 32'h0,        32'h99999999, 0, 1, 1, 32'h0C,       32'h1111000C, 3'd1, 1);
    tv[12] = mk(0, 32'h0,        32'h99999999, 0, 1, 0, 32'h0,        32'h0,        3'd0, 1);
    // flush while the fill is pending
    tv[13] = mk(1, 32'h100,      32'h0,        0, 0, 0, 32'h0,        32'h0,        3'd0, 1);
    tv[14] = mk(1, 32'h200,      32'hCAFEF00D, 1, 1, 1, 32'h100,      32'hCAFEF00D, 3'd1, 0);
    tv[15] = mk(0, 32'h0,        32'h12345678, 0, 0, 0, 32'h0,        32'h0,        3'd0, 1);

    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_count", {29'b0, count}, 32'h0);
    chk("rst_ready", {31'b0, if_req_ready}, 32'h1);
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(tv[i].req, tv[i].pc, tv[i].rd, tv[i].fl, tv[i].idr);
      #3;
      chk($sformatf("v%0d_valid", i), {31'b0, id_valid}, {31'b0, tv[i].ev});
      chk($sformatf("v%0d_pc", i), id_pc, tv[i].epc);
      chk($sformatf("v%0d_inst", i), id_inst, tv[i].einst);
      chk($sformatf("v%0d_count", i), {29'b0, count}, {29'b0, tv[i].ecnt});
      chk($sformatf("v%0d_ready", i), {31'b0, if_req_ready}, {31'b0, tv[i].erdy});
      tick();
    end

    // bypass value is captured and held across a stall
    drive(1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'hAAAA5555, 1'b0, 1'b0);
    #3;
    chk("hold_byp", id_inst, 32'hAAAA5555);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 32'h0BAD0000 + k, 1'b0, 1'b0);
      #3;
      chk($sformatf("hold%0d_inst", k), id_inst, 32'hAAAA5555);
      chk($sformatf("hold%0d_pc", k), id_pc, 32'h40);
      chk($sformatf("hold%0d_count", k), {29'b0, count}, 32'h1);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    #3;
    chk("hold_drained", {29'b0, count}, 32'h0);
    tick();

    // concurrent push/pop across pointer wrap
    drive(1'b1, 32'h1000, 32'h0, 1'b0, 1'b1);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'h1000 + 4 * i, 32'h50000000 + i - 1, 1'b0, 1'b1);
      #3;
      chk($sformatf("wrap%0d_pc", i), id_pc, 32'h1000 + 4 * (i - 1));
      chk($sformatf("wrap%0d_inst", i), id_inst, 32'h50000000 + i - 1);
      chk($sformatf("wrap%0d_count", i), {29'b0, count}, 32'h1);
      tick();
    end
    drive(1'b0, 32'h0, 32'h5000000A, 1'b0, 1'b1);
    #3;
    chk("wrap_last_pc", id_pc, 32'h1028);
    tick();
    #3;
    chk("wrap_empty", {29'b0, count}, 32'h0);
    tick();

    // async reset between edges with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h2000 + 4 * i, 32'h60000000 + i, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h60000003, 1'b0, 1'b0);
    #1;
    chk("ar_pre_count", {29'b0, count}, 32'h3);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_count", {29'b0, count}, 32'h0);
    chk("ar_valid", {31'b0, id_valid}, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h77777777, 1'b0, 1'b0);
    #3;
    chk("ar_after_valid", {31'b0, id_valid}, 32'h0);
    chk("ar_after_inst", id_inst, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
